// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, prefetches ROM words into a small queue, and hands them to decode.
// A word fetched in cycle t is at the outputs in cycle t+1; fetch stalls while the queue is full and decode is not accepting.
module fetch_ctrl #(
  parameter int           N         = 32,
  parameter int           DEPTH     = 2,
  parameter logic [63:0]  RESET_PC  = 64'h0,
  parameter logic [N-1:0] HALT_INSN = 32'hb400001f
) (
  input  logic         clk,
  input  logic         reset,
  output logic [5:0]   imem_addr,
  input  logic [N-1:0] imem_q,
  input  logic         redirect_valid,
  input  logic [63:0]  redirect_pc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_instr,
  output logic [63:0]  out_pc,
  output logic         halted,
  output logic [15:0]  fetch_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  state_t        state;
  logic [63:0]   fetch_pc;
  logic [N-1:0]  q_instr [DEPTH];
  logic [63:0]   q_pc    [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          flush;
  logic          push;
  logic          pop;

  assign imem_addr = fetch_pc[7:2];
  assign out_valid = (count != '0) && (state != HALT);
  assign out_instr = q_instr[rd_ptr];
  assign out_pc    = q_pc[rd_ptr];
  assign pop       = out_valid && out_ready;
  assign flush     = redirect_valid && (state != HALT);
  // At full, a same-cycle pop frees the slot the push writes into.
  assign push      = (state == RUN) && !flush && ((count != FULL) || pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        q_instr[wr_ptr] <= imem_q;
        q_pc[wr_ptr]    <= fetch_pc;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      if (pop && (fetch_count != 16'hFFFF)) fetch_count <= fetch_count + 1'b1;
      if (flush) begin
        state    <= RUN;
        fetch_pc <= redirect_pc & ~64'h3;
      end else begin
        case (state)
          RUN: begin
            // The halt word is the last thing fetched; its PC is held.
            if (push) begin
              if (imem_q == HALT_INSN) state <= DRAIN;
              else fetch_pc <= fetch_pc + 64'd4;
            end
          end
          DRAIN: begin
            if (pop && (out_instr == HALT_INSN)) begin
              state  <= HALT;
              halted <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_fetch_ctrl;
  localparam int DEPTH = 2;
  localparam logic [31:0] HALT = 32'hb400001f;
  localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  imem_addr;
  logic [31:0] imem_q;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        halted;
  logic [15:0] fetch_count;

  logic [31:0] rom [64];

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [95:0] mq[$];
  logic [63:0] mpc;
  int          mmode;
  logic        mhalted;
  logic [15:0] mcnt;

  fetch_ctrl #(.N(32), .DEPTH(DEPTH), .RESET_PC(64'h0), .HALT_INSN(HALT)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_q(imem_q),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;
  assign imem_q = rom[imem_addr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpc = 64'h0;
    mmode = M_RUN;
    mhalted = 1'b0;
    mcnt = 16'h0;
  endtask

  task automatic model_edge();
    logic        popped;
    logic [95:0] h;
    logic [31:0] w;
    int          pm;
    pm = mmode;
    h = '0;
    popped = (mq.size() > 0) && (mmode != M_HALT) && out_ready;
    if (popped) begin
      h = mq.pop_front();
      if (mcnt != 16'hFFFF) mcnt++;
    end
    if (redirect_valid && pm != M_HALT) begin
      mq.delete();
      mpc = redirect_pc & ~64'h3;
      mmode = M_RUN;
    end else if (pm == M_DRAIN) begin
      if (popped && h[31:0] == HALT) begin
        mmode = M_HALT;
        mhalted = 1'b1;
      end
    end else if (pm == M_RUN && mq.size() < DEPTH) begin
      w = rom[mpc[7:2]];
      mq.push_back({mpc, w});
      if (w == HALT) mmode = M_DRAIN;
      else mpc = mpc + 64'd4;
    end
  endtask

  task automatic cmp_model();
    logic        mv;
    logic [95:0] h;
    mv = (mq.size() > 0) && (mmode != M_HALT);
    check("out_valid", 64'(out_valid), 64'(mv));
    if (mv) begin
      h = mq[0];
      check("out_instr", 64'(out_instr), 64'(h[31:0]));
      check("out_pc", out_pc, h[95:32]);
    end
    check("halted", 64'(halted), 64'(mhalted));
    check("fetch_count", 64'(fetch_count), 64'(mcnt));
    check("imem_addr", 64'(imem_addr), 64'(mpc[7:2]));
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_edge();
    @(negedge clk);
    cmp_model();
  endtask

  // Called at a falling edge: asserts reset between edges and checks the immediate clear.
  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check({tag, "_valid"}, 64'(out_valid), 64'h0);
    check({tag, "_instr"}, 64'(out_instr), 64'h0);
    check({tag, "_pc"}, out_pc, 64'h0);
    check({tag, "_cnt"}, 64'(fetch_count), 64'h0);
    check({tag, "_halted"}, 64'(halted), 64'h0);
    @(negedge clk);
    cmp_model();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h1000_0000 | 32'(i);
    rom[0]  = 32'hf8000001;
    rom[1]  = 32'hf8008002;
    rom[2]  = 32'hf8000203;
    rom[36] = 32'h8b080000;
    rom[37] = 32'hb4ffff82;
    rom[45] = 32'hf81f83d9;
    rom[46] = HALT;
    rom[63] = 32'h0;
  end

  initial begin
    reset = 1'b0;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 64'h0;
    model_reset();
    repeat (2) @(negedge clk);
    cmp_model();
    check("rst_instr", 64'(out_instr), 64'h0);
    check("rst_pc", out_pc, 64'h0);

    // 1: stream from reset
    reset = 1'b1;
    #1 check("t1_pre_valid", 64'(out_valid), 64'h0);
    step(); check("t1_w0", 64'(out_instr), 64'hf8000001); check("t1_p0", out_pc, 64'h0);
    step(); check("t1_w1", 64'(out_instr), 64'hf8008002); check("t1_p1", out_pc, 64'h4);
    step(); check("t1_w2", 64'(out_instr), 64'hf8000203); check("t1_p2", out_pc, 64'h8);
    step(); check("t1_cnt", 64'(fetch_count), 64'd3);

    // 2: backpressure from reset
    async_reset("t2_rst");
    out_ready = 1'b0;
    reset = 1'b1;
    repeat (5) step();
    check("t2_addr", 64'(imem_addr), 64'd2);
    check("t2_hold", 64'(out_instr), 64'hf8000001);
    out_ready = 1'b1;
    check("t2_d0", 64'(out_instr), 64'hf8000001);
    step(); check("t2_d1", 64'(out_instr), 64'hf8008002);
    step(); check("t2_d2", 64'(out_instr), 64'hf8000203);

    // 3: redirect with a full queue
    out_ready = 1'b0;
    repeat (2) step();
    redirect_valid = 1'b1; redirect_pc = 64'h92;
    step();
    redirect_valid = 1'b0;
    check("t3_flush", 64'(out_valid), 64'h0);
    out_ready = 1'b1;
    step(); check("t3_w0", 64'(out_instr), 64'h8b080000); check("t3_p0", out_pc, 64'h90);
    step(); check("t3_w1", 64'(out_instr), 64'hb4ffff82); check("t3_p1", out_pc, 64'h94);

    // 4: halt
    redirect_valid = 1'b1; redirect_pc = 64'hB4;
    step();
    redirect_valid = 1'b0;
    step(); check("t4_w0", 64'(out_instr), 64'hf81f83d9); check("t4_p0", out_pc, 64'hB4);
    step(); check("t4_w1", 64'(out_instr), 64'hb400001f); check("t4_p1", out_pc, 64'hB8);
    check("t4_not_yet", 64'(halted), 64'h0);
    step(); check("t4_halted", 64'(halted), 64'h1);
    for (int i = 0; i < 20; i++) begin
      redirect_valid = (i == 5);
      redirect_pc = 64'h0;
      step();
      check("t4_quiet", 64'(out_valid), 64'h0);
    end
    redirect_valid = 1'b0;
    check("t4_addr_held", 64'(imem_addr), 64'd46);

    // 5: address wrap
    async_reset("t5_rst");
    reset = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 64'hFC;
    step();
    redirect_valid = 1'b0;
    check("t5_addr63", 64'(imem_addr), 64'd63);
    step(); check("t5_w0", 64'(out_instr), 64'h0); check("t5_p0", out_pc, 64'hFC);
    check("t5_addr0", 64'(imem_addr), 64'd0);
    step(); check("t5_w1", 64'(out_instr), 64'hf8000001); check("t5_p1", out_pc, 64'h100);

    // 6: reset mid-operation with a full queue
    out_ready = 1'b0;
    repeat (2) step();
    async_reset("t6_rst");
    reset = 1'b1;
    out_ready = 1'b1;
    step(); check("t6_w0", 64'(out_instr), 64'hf8000001); check("t6_p0", out_pc, 64'h0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 149) == 0) begin
        async_reset("rnd_rst");
        reset = 1'b1;
      end
      out_ready = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0: redirect_pc = 64'hB4;
        1: redirect_pc = 64'(($urandom_range(0, 255)));
        default: redirect_pc = {$urandom, $urandom};
      endcase
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
